// File: rtl/store_pkg.sv
// Shared types for the store narrower: size encodings, write-buffer entry, depth bounds.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } st_size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wb_entry_t;

  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;

  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/store_lane_mux.sv
// Combinational store narrowing: lane select, data replication, byte enables.
// STORE_MISALIGN_TRAP_EN enables the alignment check on half/word stores.
module store_lane_mux
  import store_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output wb_entry_t   entry,
  output logic        misaligned,
  output logic        rsvd
);

  logic [1:0] lane;

  always_comb begin
    lane        = st_addr[1:0] ^ {2{BIG_ENDIAN}};
    entry.addr  = {st_addr[31:2], 2'b00};
    entry.wdata = st_data;
    entry.be    = 4'b0000;
    misaligned  = 1'b0;
    rsvd        = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        entry.wdata = {4{st_data[7:0]}};
        entry.be    = lane_onehot(lane);
      end
      SZ_HALF: begin
        entry.wdata = {2{st_data[15:0]}};
        // addr[1] picks the half; endianness flips which lanes that is
        entry.be    = (st_addr[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
`ifdef STORE_MISALIGN_TRAP_EN
        misaligned  = st_addr[0];
`endif
      end
      SZ_WORD: begin
        entry.wdata = st_data;
        entry.be    = 4'b1111;
`ifdef STORE_MISALIGN_TRAP_EN
        misaligned  = |st_addr[1:0];
`endif
      end
      default: begin
        rsvd = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrower.sv
// Store narrower with an in-order write buffer draining over valid/ready.
// Build option: STORE_MISALIGN_TRAP_EN rejects misaligned half/word stores.
module store_narrower
  import store_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [1:0]                 st_size,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t new_entry;
  logic      misaligned;
  logic      rsvd;
  logic      reject;
  logic      push;
  logic      pop;

  wb_entry_t wb_mem [DEPTH];
  wb_entry_t head_reg, head_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next, remain;
  logic          mem_valid_reg;
  logic          err_reg;

  store_lane_mux #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane_mux (
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_size    (st_size),
    .entry      (new_entry),
    .misaligned (misaligned),
    .rsvd       (rsvd)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign reject   = rsvd | misaligned;
  assign st_ready = (count_reg < CW'(DEPTH));
  assign push     = st_valid & st_ready & ~reject;
  assign pop      = mem_valid_reg & mem_ready;

  always_comb begin
    wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    remain      = pop  ? count_reg - 1'b1 : count_reg;
    count_next  = push ? remain + 1'b1 : remain;
    // Head register preloads the next entry so mem_* stay flop outputs
    if (remain != '0)
      head_next = wb_mem[rd_ptr_next];
    else if (push)
      head_next = new_entry;
    else
      head_next = head_reg;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PW'(gi)))
          wb_mem[gi] <= new_entry;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      mem_valid_reg <= 1'b0;
      head_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      mem_valid_reg <= (count_next != '0);
      head_reg      <= head_next;
      err_reg       <= st_valid & reject;
    end
  end

  assign mem_valid    = mem_valid_reg;
  assign mem_addr     = head_reg.addr;
  assign mem_wdata    = head_reg.wdata;
  assign mem_be       = head_reg.be;
  assign misalign_err = err_reg;
  assign count        = count_reg;

endmodule

// File: tb/tb_store_narrower.sv
// Directed bench for store_narrower: big-endian DUT plus a little-endian twin on shared inputs.
module tb_store_narrower;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_ready;

  logic        st_ready, mem_valid, misalign_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [1:0]  count;

  logic        le_st_ready, le_mem_valid, le_misalign_err;
  logic [31:0] le_mem_addr, le_mem_wdata;
  logic [3:0]  le_mem_be;
  logic [1:0]  le_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  store_narrower #(.DEPTH(2), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .misalign_err(misalign_err), .count(count)
  );

  store_narrower #(.DEPTH(2), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(le_st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_valid(le_mem_valid), .mem_ready(mem_ready),
    .mem_addr(le_mem_addr), .mem_wdata(le_mem_wdata), .mem_be(le_mem_be),
    .misalign_err(le_misalign_err), .count(le_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick; tick;
    rst_n = 1'b1;
    tick;
    n_chk++;
    if ({mem_valid, mem_addr, mem_wdata, mem_be, misalign_err, count, st_ready} !==
        {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: valid=%b addr=%h wdata=%h be=%b err=%b count=%0d ready=%b, required 0/0/0/0000/0/0/1",
               mem_valid, mem_addr, mem_wdata, mem_be, misalign_err, count, st_ready);
    end
    $display("reset: valid=%b count=%0d ready=%b", mem_valid, count, st_ready);
  endtask

  task automatic test_byte;
    drive(1'b1, 32'h0000_1001, 32'h1234_5678, 2'b00);
    tick;
    st_valid = 1'b0;
    n_chk++;
    if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h0000_1000, 32'h7878_7878, 4'b0100}) begin
      n_fail++;
      $display("FAIL byte_be: got v=%b a=%h d=%h be=%b, required 1 00001000 78787878 0100",
               mem_valid, mem_addr, mem_wdata, mem_be);
    end
    n_chk++;
    if ({le_mem_valid, le_mem_wdata, le_mem_be} !== {1'b1, 32'h7878_7878, 4'b0010}) begin
      n_fail++;
      $display("FAIL byte_le: got v=%b d=%h be=%b, required 1 78787878 0010", le_mem_valid, le_mem_wdata, le_mem_be);
    end
    $display("byte: addr=%h wdata=%h be=%b le_be=%b", mem_addr, mem_wdata, mem_be, le_mem_be);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    n_chk++;
    if ({mem_valid, count} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL byte_drain: got v=%b count=%0d, required 0 0", mem_valid, count);
    end
  endtask

  task automatic test_half;
    drive(1'b1, 32'h0000_2002, 32'hAAAA_BEEF, 2'b01);
    tick;
    st_valid = 1'b0;
    n_chk++;
    if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b0011}) begin
      n_fail++;
      $display("FAIL half_be: got v=%b a=%h d=%h be=%b, required 1 00002000 beefbeef 0011",
               mem_valid, mem_addr, mem_wdata, mem_be);
    end
    n_chk++;
    if ({le_mem_wdata, le_mem_be} !== {32'hBEEF_BEEF, 4'b1100}) begin
      n_fail++;
      $display("FAIL half_le: got d=%h be=%b, required beefbeef 1100", le_mem_wdata, le_mem_be);
    end
    $display("half: addr=%h wdata=%h be=%b le_be=%b", mem_addr, mem_wdata, mem_be, le_mem_be);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
  endtask

  task automatic test_word;
    drive(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 2'b10);
    #3;
    n_chk++;
    if (mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL word_early: mem_valid=%b before push edge, required 0", mem_valid);
    end
    tick;
    st_valid = 1'b0;
    n_chk++;
    if ({mem_valid, mem_addr, mem_wdata, mem_be, count} !== {1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 2'd1}) begin
      n_fail++;
      $display("FAIL word: got v=%b a=%h d=%h be=%b count=%0d, required 1 00003000 deadbeef 1111 1",
               mem_valid, mem_addr, mem_wdata, mem_be, count);
    end
    $display("word: addr=%h wdata=%h be=%b", mem_addr, mem_wdata, mem_be);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
  endtask

  task automatic test_misalign;
    drive(1'b1, 32'h0000_3002, 32'hCAFE_F00D, 2'b10);
    tick;
    st_valid = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    n_chk++;
    if ({misalign_err, count, mem_valid} !== {1'b1, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL misalign_trap: got err=%b count=%0d v=%b, required 1 0 0", misalign_err, count, mem_valid);
    end
    $display("misaligned word: err=%b count=%0d", misalign_err, count);
    tick;
`else
    n_chk++;
    if ({misalign_err, count, mem_valid, mem_addr, mem_be} !== {1'b0, 2'd1, 1'b1, 32'h0000_3000, 4'b1111}) begin
      n_fail++;
      $display("FAIL misalign_notrap: got err=%b count=%0d v=%b a=%h be=%b, required 0 1 1 00003000 1111",
               misalign_err, count, mem_valid, mem_addr, mem_be);
    end
    $display("misaligned word (no trap): err=%b addr=%h be=%b", misalign_err, mem_addr, mem_be);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
`endif
    n_chk++;
    if (misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_pulse: err=%b one cycle later, required 0", misalign_err);
    end
    drive(1'b1, 32'h0000_3004, 32'h1111_2222, 2'b11);
    tick;
    st_valid = 1'b0;
    n_chk++;
    if ({misalign_err, count, mem_valid} !== {1'b1, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rsvd: got err=%b count=%0d v=%b, required 1 0 0", misalign_err, count, mem_valid);
    end
    $display("reserved size: err=%b count=%0d", misalign_err, count);
    tick;
    n_chk++;
    if (misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rsvd_pulse: err=%b one cycle later, required 0", misalign_err);
    end
  endtask

  task automatic test_back_to_back;
    mem_ready = 1'b0;
    drive(1'b1, 32'h0000_4000, 32'h1111_1111, 2'b10);
    tick;
    n_chk++;
    if ({count, st_ready, mem_addr} !== {2'd1, 1'b1, 32'h0000_4000}) begin
      n_fail++;
      $display("FAIL b2b_a: got count=%0d ready=%b a=%h, required 1 1 00004000", count, st_ready, mem_addr);
    end
    drive(1'b1, 32'h0000_4004, 32'h2222_2222, 2'b10);
    tick;
    n_chk++;
    if ({count, st_ready} !== {2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_full: got count=%0d ready=%b, required 2 0", count, st_ready);
    end
    drive(1'b1, 32'h0000_4008, 32'h3333_3333, 2'b10);
    tick;
    n_chk++;
    if ({count, mem_addr, mem_wdata} !== {2'd2, 32'h0000_4000, 32'h1111_1111}) begin
      n_fail++;
      $display("FAIL b2b_hold: got count=%0d a=%h d=%h, required 2 00004000 11111111", count, mem_addr, mem_wdata);
    end
    $display("b2b: full, head addr=%h", mem_addr);
    mem_ready = 1'b1;
    tick;
    n_chk++;
    if ({mem_valid, count, mem_addr, mem_wdata} !== {1'b1, 2'd1, 32'h0000_4004, 32'h2222_2222}) begin
      n_fail++;
      $display("FAIL b2b_popA: got v=%b count=%0d a=%h d=%h, required 1 1 00004004 22222222",
               mem_valid, count, mem_addr, mem_wdata);
    end
    $display("b2b: popped A, head addr=%h", mem_addr);
    tick;
    st_valid = 1'b0;
    n_chk++;
    if ({mem_valid, count, mem_addr, mem_wdata} !== {1'b1, 2'd1, 32'h0000_4008, 32'h3333_3333}) begin
      n_fail++;
      $display("FAIL b2b_simul: got v=%b count=%0d a=%h d=%h, required 1 1 00004008 33333333",
               mem_valid, count, mem_addr, mem_wdata);
    end
    $display("b2b: push C + pop B, head addr=%h count=%0d", mem_addr, count);
    tick;
    mem_ready = 1'b0;
    n_chk++;
    if ({mem_valid, count, st_ready} !== {1'b0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_empty: got v=%b count=%0d ready=%b, required 0 0 1", mem_valid, count, st_ready);
    end
  endtask

  task automatic test_async_reset;
    mem_ready = 1'b0;
    drive(1'b1, 32'h0000_5000, 32'h5555_5555, 2'b10);
    tick;
    drive(1'b1, 32'h0000_5004, 32'h6666_6666, 2'b10);
    tick;
    st_valid  = 1'b0;
    mem_ready = 1'b1;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({mem_valid, mem_addr, mem_wdata, mem_be, misalign_err, count, st_ready} !==
        {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: v=%b a=%h d=%h be=%b err=%b count=%0d ready=%b, required 0/0/0/0000/0/0/1",
               mem_valid, mem_addr, mem_wdata, mem_be, misalign_err, count, st_ready);
    end
    $display("async reset mid-drain: v=%b count=%0d", mem_valid, count);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    tick;
    n_chk++;
    if ({mem_valid, count} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL post_reset: got v=%b count=%0d, required 0 0", mem_valid, count);
    end
  endtask

  initial begin
    test_reset;
    test_byte;
    test_half;
    test_word;
    test_misalign;
    test_back_to_back;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
